// File: rtl/dac_stream_pkg.sv
// ============================================================================
//  dac_stream_pkg
//  Shared constants and the pacing state encoding for the DAC sample streamer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package dac_stream_pkg;

  localparam int DAC_W         = 10;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } stream_state_t;

endpackage

`default_nettype wire

// File: rtl/dac_sample_fifo.sv
// ============================================================================
//  dac_sample_fifo
//  Synchronous FIFO holding DAC samples between the core and the pacer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dac_sample_fifo
  import dac_stream_pkg::*;
#(
  parameter int  DW    = DAC_W,
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_wr;
  logic          w_rd;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign level = r_wptr - r_rptr;
  assign rdata = r_mem[r_rptr[AW-1:0]];

  assign w_wr = push && !full;
  assign w_rd = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/dac_sample_streamer.sv
// ============================================================================
//  dac_sample_streamer
//  Buffers core samples and paces them onto the DAC D input at a set rate.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dac_sample_streamer
  import dac_stream_pkg::*;
#(
  parameter int            DW       = DAC_W,
  parameter int            DEPTH    = DEFAULT_DEPTH,
  parameter int            DIV_W    = DEFAULT_DIV_W,
  parameter logic [DW-1:0] RST_CODE = '0,
  localparam int           LW       = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    D,
  output logic             strobe,
  output logic [LW-1:0]    level,
  output logic             underflow,
  input  logic             clr_underflow,
  output logic [1:0]       state
);

  logic [DIV_W-1:0] r_cnt;
  logic [DW-1:0]    r_d;
  logic             r_strobe;
  logic             r_underflow;
  stream_state_t    r_state;
  stream_state_t    w_state_nxt;

  logic             w_tick;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [DW-1:0]    w_head;

  assign in_ready  = !w_full;
  assign w_push    = in_valid && !w_full;
  assign w_tick    = en && (r_cnt == div);
  assign w_pop     = w_tick && !w_empty;

  assign D         = r_d;
  assign strobe    = r_strobe;
  assign underflow = r_underflow;
  assign state     = r_state;

  dac_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_data),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  // Free-running up-counter; a div lowered below cnt is reached after wrap.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!en || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_d      <= RST_CODE;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_pop;
      if (w_pop) r_d <= w_head;
    end
  end

  // An empty tick wins over a same-cycle clear so no underflow is lost.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else if (w_tick && w_empty) begin
      r_underflow <= 1'b1;
    end else if (clr_underflow) begin
      r_underflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     if (w_tick && w_empty)  w_state_nxt = STARVED;
        STARVED: if (w_tick && !w_empty) w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dac_sample_streamer.sv
// ============================================================================
//  tb_dac_sample_streamer
//  Directed scenario bench for dac_sample_streamer with hand-computed vectors.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dac_sample_streamer;

  logic        CLK = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] div;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  D;
  logic        strobe;
  logic [3:0]  level;
  logic        underflow;
  logic        clr_underflow;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  dac_sample_streamer #(
    .DW       (10),
    .DEPTH    (8),
    .DIV_W    (16),
    .RST_CODE (10'd0)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .en            (en),
    .div           (div),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .D             (D),
    .strobe        (strobe),
    .level         (level),
    .underflow     (underflow),
    .clr_underflow (clr_underflow),
    .state         (state)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; div = '0; in_data = '0; in_valid = 1'b0; clr_underflow = 1'b0;
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++; if (D !== 10'd0) begin n_err++; $display("FAIL reset_D: got %0h want 0", D); end
      n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
      n_vec++; if (strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b want 0", strobe); end
      n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    end
  endtask

  task automatic test_pacing();
    logic [9:0] smp [3];
    logic [9:0] exp_d;
    logic [3:0] exp_lvl;
    smp[0] = 10'h000; smp[1] = 10'h155; smp[2] = 10'h3FF;
    div = 16'd3;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = smp[i];
      step();
    end
    in_valid = 1'b0;
    n_vec++; if (level !== 4'd3) begin n_err++; $display("FAIL pace_prefill_level: got %0d want 3", level); end
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_d   = (k < 8) ? smp[0] : (k < 12) ? smp[1] : smp[2];
      exp_lvl = (k < 4) ? 4'd3 : (k < 8) ? 4'd2 : (k < 12) ? 4'd1 : 4'd0;
      n_vec++; if (D !== exp_d) begin n_err++; $display("FAIL pace_D k=%0d: got %0h want %0h", k, D, exp_d); end
      n_vec++; if (strobe !== (k % 4 == 0)) begin n_err++; $display("FAIL pace_strobe k=%0d: got %b want %b", k, strobe, (k % 4 == 0)); end
      n_vec++; if (level !== exp_lvl) begin n_err++; $display("FAIL pace_level k=%0d: got %0d want %0d", k, level, exp_lvl); end
      n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL pace_state k=%0d: got %0d want 1", k, state); end
    end
    step(); step(); step(); step();
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL pace_dry_underflow: got %b want 1", underflow); end
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL pace_dry_state: got %0d want 2", state); end
    n_vec++; if (D !== 10'h3FF) begin n_err++; $display("FAIL pace_dry_D: got %0h want 3ff", D); end
    en = 1'b0; clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL pace_clear_underflow: got %b want 0", underflow); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL pace_idle_state: got %0d want 0", state); end
  endtask

  task automatic test_full();
    logic [9:0] smp [9];
    int got;
    int cyc;
    logic pending;
    for (int i = 0; i < 9; i++) smp[i] = 10'(64 + i);
    en = 1'b0; div = '0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = smp[i];
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_before i=%0d: got %b want 1", i, in_ready); end
      step();
    end
    in_data = smp[8];
    step(); step();
    n_vec++; if (level !== 4'd8) begin n_err++; $display("FAIL full_level: got %0d want 8", level); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", in_ready); end
    en = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 9 && cyc < 30) begin
      pending = in_valid && in_ready;
      step();
      cyc++;
      if (pending) in_valid = 1'b0;
      if (strobe === 1'b1) begin
        n_vec++; if (D !== smp[got]) begin n_err++; $display("FAIL full_drain_D n=%0d: got %0h want %0h", got, D, smp[got]); end
        got++;
      end
    end
    in_valid = 1'b0;
    n_vec++; if (got !== 9) begin n_err++; $display("FAIL full_drain_count: got %0d want 9", got); end
    en = 1'b0; clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
  endtask

  task automatic test_underflow();
    div = 16'd1;
    in_valid = 1'b1; in_data = 10'h2AA;
    step();
    in_valid = 1'b0;
    en = 1'b1;
    step();
    step();
    n_vec++; if (D !== 10'h2AA) begin n_err++; $display("FAIL uf_D: got %0h want 2aa", D); end
    n_vec++; if (strobe !== 1'b1) begin n_err++; $display("FAIL uf_strobe: got %b want 1", strobe); end
    step();
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_early: got %b want 0", underflow); end
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL uf_state_run: got %0d want 1", state); end
    step();
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set: got %b want 1", underflow); end
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL uf_state_starved: got %0d want 2", state); end
    n_vec++; if (D !== 10'h2AA) begin n_err++; $display("FAIL uf_D_hold: got %0h want 2aa", D); end
    n_vec++; if (strobe !== 1'b0) begin n_err++; $display("FAIL uf_strobe_low: got %b want 0", strobe); end
    step();
    clr_underflow = 1'b1;
    step();
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set_priority: got %b want 1", underflow); end
    en = 1'b0;
    step();
    clr_underflow = 1'b0;
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear: got %b want 0", underflow); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL uf_state_idle: got %0d want 0", state); end
  endtask

  task automatic test_back_to_back();
    div = '0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 10'(i);
      step();
    end
    in_valid = 1'b0;
    n_vec++; if (level !== 4'd8) begin n_err++; $display("FAIL b2b_prefill: got %0d want 8", level); end
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_vec++; if (D !== 10'(k)) begin n_err++; $display("FAIL b2b_D k=%0d: got %0h want %0h", k, D, k); end
      n_vec++; if (strobe !== 1'b1) begin n_err++; $display("FAIL b2b_strobe k=%0d: got %b want 1", k, strobe); end
      n_vec++; if (level !== 4'(8 - k)) begin n_err++; $display("FAIL b2b_level k=%0d: got %0d want %0d", k, level, 8 - k); end
    end
    in_valid = 1'b1; in_data = 10'h0AA;
    step();
    n_vec++; if (level !== 4'd1) begin n_err++; $display("FAIL b2b_push_empty_level: got %0d want 1", level); end
    n_vec++; if (D !== 10'h008 || strobe !== 1'b0) begin n_err++; $display("FAIL b2b_no_forward: got D=%0h s=%b want D=8 s=0", D, strobe); end
    in_data = 10'h0BB;
    step();
    in_valid = 1'b0;
    n_vec++; if (level !== 4'd1) begin n_err++; $display("FAIL b2b_push_pop_level: got %0d want 1", level); end
    n_vec++; if (D !== 10'h0AA) begin n_err++; $display("FAIL b2b_push_pop_D: got %0h want aa", D); end
    step();
    n_vec++; if (D !== 10'h0BB || level !== 4'd0) begin n_err++; $display("FAIL b2b_last: got D=%0h lvl=%0d want D=bb lvl=0", D, level); end
    en = 1'b0; clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
  endtask

  task automatic test_reset_mid();
    div = '0; en = 1'b1;
    step();
    div = 16'hFFFF;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 10'(256 + i);
      step();
    end
    in_valid = 1'b0;
    n_vec++; if (level !== 4'd5) begin n_err++; $display("FAIL mid_pre_level: got %0d want 5", level); end
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL mid_pre_underflow: got %b want 1", underflow); end
    #3 reset = 1'b1;
    #1;
    n_vec++; if (D !== 10'd0) begin n_err++; $display("FAIL mid_D: got %0h want 0", D); end
    n_vec++; if (level !== 4'd0) begin n_err++; $display("FAIL mid_level: got %0d want 0", level); end
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL mid_underflow: got %b want 0", underflow); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL mid_state: got %0d want 0", state); end
    en = 1'b0;
    step();
    reset = 1'b0;
    step();
    n_vec++; if (level !== 4'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_after: got lvl=%0d rdy=%b want 0/1", level, in_ready); end
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_full();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
